// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl
//   Captures an unsigned binary value and shows it on DIGITS active-low
//   7-segment digits, either as hexadecimal or as decimal. The decimal
//   conversion is a shift-add-3 (double-dabble) pass, one bit per clock.
//   Leading-zero blanking, blinking and the display enable act
//   combinationally on the registered digits and never restart a conversion.
//
// Ports
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   value     binary number to display (WIDTH bits)
//   load      capture value/mode when idle; ignored while busy
//   mode      0 = hexadecimal, 1 = decimal
//   blank_lz  blank leading zero digits (digit 0 always shown)
//   blink_en  blank all digits during the off phase of the blink timer
//   enable    0 blanks all digits
//   hex_out   active-low segments gfedcba, digit k at [7k+6:7k]
//   busy      conversion in progress
//   ovf       last captured value did not fit in DIGITS digits
//
// state  | meaning
// IDLE   | waiting for load; digits and ovf hold their last result
// CONV   | hex: one cycle of nibble extraction; decimal: WIDTH shift-add-3 steps
// UPDATE | result and ovf written to the digit register, then back to IDLE

module seg_display_ctrl #(
  parameter int DIGITS    = 6,
  parameter int WIDTH     = 20,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      value,
  input  logic                  load,
  input  logic                  mode,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  input  logic                  enable,
  output logic [7*DIGITS-1:0]   hex_out,
  output logic                  busy,
  output logic                  ovf
);

  localparam int BCDW = 4 * DIGITS;
  localparam int PADW = (WIDTH > BCDW) ? WIDTH : BCDW;
  localparam int CNTW = $clog2(WIDTH);
  localparam int BLKW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_UPDATE
  } state_e;

  state_e            state_q,   state_d;
  logic [WIDTH-1:0]  value_q,   value_d;    // captured value, shifted out MSB-first in decimal mode
  logic              mode_q,    mode_d;
  logic [BCDW-1:0]   bcd_q,     bcd_d;      // working result, copied to digits_q in UPDATE
  logic [CNTW-1:0]   cnt_q,     cnt_d;      // remaining shift steps, terminal count 0
  logic              ovf_acc_q, ovf_acc_d;
  logic [BCDW-1:0]   digits_q,  digits_d;
  logic              ovf_q,     ovf_d;
  logic [BLKW-1:0]   blk_cnt_q, blk_cnt_d;
  logic              blk_on_q,  blk_on_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Conversion FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      value_q   <= '0;
      mode_q    <= 1'b0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      mode_q    <= mode_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
    end
  end

  logic [BCDW-1:0] bcd_adj;
  logic [PADW-1:0] val_pad;

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    mode_d    = mode_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    digits_d  = digits_q;
    ovf_d     = ovf_q;

    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    val_pad = PADW'(value_q);

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          value_d   = value;
          mode_d    = mode;
          bcd_d     = '0;
          cnt_d     = CNTW'(WIDTH - 1);
          ovf_acc_d = 1'b0;
          state_d   = ST_CONV;
        end
      end
      ST_CONV: begin
        if (mode_q) begin
          // A set MSB after add-3 is a carry out of the top BCD digit.
          bcd_d     = {bcd_adj[BCDW-2:0], value_q[WIDTH-1]};
          ovf_acc_d = ovf_acc_q | bcd_adj[BCDW-1];
          value_d   = value_q << 1;
          if (cnt_q == '0) state_d = ST_UPDATE;
          else             cnt_d   = cnt_q - CNTW'(1);
        end else begin
          bcd_d     = val_pad[BCDW-1:0];
          // Shift evaluates to zero when nothing is truncated.
          ovf_acc_d = |(val_pad >> BCDW);
          state_d   = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        digits_d = (mode_q && ovf_acc_q) ? BCDW'({DIGITS{4'h9}}) : bcd_q;
        ovf_d    = ovf_acc_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Free-running blink timer, phase toggles every BLINK_DIV cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_cnt_q <= '0;
      blk_on_q  <= 1'b1;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      blk_on_q  <= blk_on_d;
    end
  end

  always_comb begin
    blk_cnt_d = blk_cnt_q + BLKW'(1);
    blk_on_d  = blk_on_q;
    if (blk_cnt_q == BLKW'(BLINK_DIV - 1)) begin
      blk_cnt_d = '0;
      blk_on_d  = ~blk_on_q;
    end
  end

  // Display path: scan from the top digit so zero_above tracks leading zeros.
  logic zero_above;
  logic blank_all;

  always_comb begin
    hex_out    = '1;
    zero_above = 1'b1;
    blank_all  = !enable || (blink_en && !blk_on_q);
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (digits_q[4*k +: 4] == 4'h0);
      if (blank_all || (blank_lz && (k != 0) && zero_above))
        hex_out[7*k +: 7] = 7'b1111111;
      else
        hex_out[7*k +: 7] = seg7(digits_q[4*k +: 4]);
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
module tb_seg_display_ctrl;

  localparam int DIGITS    = 6;
  localparam int WIDTH     = 20;
  localparam int BLINK_DIV = 4;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011,
                         SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110,
                         SF = 7'b0001110, SX = 7'b1111111;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [WIDTH-1:0]     value = '0;
  logic                 load = 1'b0;
  logic                 mode = 1'b0;
  logic                 blank_lz = 1'b0;
  logic                 blink_en = 1'b0;
  logic                 enable = 1'b1;
  logic [7*DIGITS-1:0]  hex_out;
  logic                 busy;
  logic                 ovf;

  seg_display_ctrl #(
    .DIGITS   (DIGITS),
    .WIDTH    (WIDTH),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .value   (value),
    .load    (load),
    .mode    (mode),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .enable  (enable),
    .hex_out (hex_out),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]    value;
    logic                mode;
    logic                blz;
    logic [7*DIGITS-1:0] exp_hex;
    logic                exp_ovf;
    int                  exp_busy;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_load(input logic [WIDTH-1:0] v, input logic m, output int cycles);
    value = v;
    mode  = m;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    logic [7*DIGITS-1:0] exp_b;

    vecs[0] = '{20'd1234,    1'b1, 1'b0, {S0,S0,S1,S2,S3,S4}, 1'b0, 21};
    vecs[1] = '{20'hABCDE,   1'b0, 1'b0, {S0,SA,SB,SC,SD,SE}, 1'b0, 2};
    vecs[2] = '{20'd1000000, 1'b1, 1'b0, {S9,S9,S9,S9,S9,S9}, 1'b1, 21};
    vecs[3] = '{20'd42,      1'b1, 1'b1, {SX,SX,SX,SX,S4,S2}, 1'b0, 21};
    vecs[4] = '{20'd0,       1'b1, 1'b1, {SX,SX,SX,SX,SX,S0}, 1'b0, 21};
    vecs[5] = '{20'd999999,  1'b1, 1'b0, {S9,S9,S9,S9,S9,S9}, 1'b0, 21};
    vecs[6] = '{20'hFFFFF,   1'b0, 1'b0, {S0,SF,SF,SF,SF,SF}, 1'b0, 2};
    vecs[7] = '{20'h00070,   1'b0, 1'b1, {SX,SX,SX,SX,S7,S0}, 1'b0, 2};
    vecs[8] = '{20'd1048575, 1'b1, 1'b0, {S9,S9,S9,S9,S9,S9}, 1'b1, 21};
    vecs[9] = '{20'd98765,   1'b1, 1'b1, {SX,S9,S8,S7,S6,S5}, 1'b0, 21};

    // Reset state
    reset_n = 1'b0;
    repeat (3) tick();
    check("reset_hex", hex_out, {S0,S0,S0,S0,S0,S0});
    check("reset_busy", busy, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    reset_n = 1'b1;
    tick();

    // Table-driven conversions
    for (int i = 0; i < NVEC; i++) begin
      blank_lz = vecs[i].blz;
      run_load(vecs[i].value, vecs[i].mode, cycles);
      check($sformatf("vec%0d_busy_len", i), cycles, vecs[i].exp_busy);
      check($sformatf("vec%0d_hex", i), hex_out, vecs[i].exp_hex);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
    end

    // Hex latency: previous digits held until the update edge at capture+2
    blank_lz = 1'b0;
    value = 20'hABCDE;
    mode  = 1'b0;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    check("hexlat_hold1", hex_out, {S0,S9,S8,S7,S6,S5});
    tick();
    check("hexlat_hold2", hex_out, {S0,S9,S8,S7,S6,S5});
    check("hexlat_busy", busy, 1'b1);
    tick();
    check("hexlat_new", hex_out, {S0,SA,SB,SC,SD,SE});
    check("hexlat_idle", busy, 1'b0);

    // Load mid-conversion ignored; enable=0 blanks but conversion proceeds
    value = 20'd1234;
    mode  = 1'b1;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      if (cycles == 3) enable = 1'b0;
      if (cycles == 4) check("en0_blank_mid", hex_out, {SX,SX,SX,SX,SX,SX});
      if (cycles == 5) begin
        value = 20'd5;
        mode  = 1'b0;
        load  = 1'b1;
      end
      if (cycles == 6) load = 1'b0;
      tick();
    end
    check("midload_busy_len", cycles, 21);
    check("en0_blank_done", hex_out, {SX,SX,SX,SX,SX,SX});
    enable = 1'b1;
    #1;
    check("midload_hex", hex_out, {S0,S0,S1,S2,S3,S4});
    check("midload_ovf", ovf, 1'b0);
    repeat (3) tick();
    check("midload_not_queued", busy, 1'b0);

    // Reset mid-conversion: immediate abort, digits zero
    run_load_start: begin
      value = 20'd999999;
      mode  = 1'b1;
      load  = 1'b1;
      tick();
      load  = 1'b0;
      repeat (5) tick();
      check("abort_busy_pre", busy, 1'b1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_hex", hex_out, {S0,S0,S0,S0,S0,S0});
    check("abort_ovf", ovf, 1'b0);
    @(posedge clk);
    #1;
    blink_en = 1'b1;
    reset_n  = 1'b1;
    #1;
    check("blink_phase0", hex_out, {S0,S0,S0,S0,S0,S0});

    // Blink: phase off after edges 4..7, on after 8..11, etc.
    for (int n = 1; n <= 16; n++) begin
      tick();
      exp_b = (((n / BLINK_DIV) % 2) == 0) ? {S0,S0,S0,S0,S0,S0} : {SX,SX,SX,SX,SX,SX};
      check($sformatf("blink_edge%0d", n), hex_out, exp_b);
    end
    check("blink_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
